// File: rtl/cpu_execute_pipe.sv
// cpu_execute_pipe: execute stage with combinational ALU/branch unit, a
// two-state data-bus FSM and an optional pipelined multiplier.
// Define EXEC_MUL_EN to build the MUL_STAGES-deep multiplier; without it
// OP_MUL behaves as an unknown opcode and p4_mult stays at zero.
// Opcode encoding: memory ops live in 6'b100_wss (w = write, ss = size).
module cpu_execute_pipe #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic [5:0]        p3_op,
    input  logic [7:0]        p3_opx,
    input  logic [XLEN-1:0]   p3_data_a,
    input  logic [XLEN-1:0]   p3_data_b,
    input  logic [XLEN-1:0]   p3_literal,
    input  logic [XLEN-1:0]   p2_pc,
    input  logic              p4_jump_taken,
    output logic              cpud_request,
    input  logic              cpud_ack,
    output logic [XLEN-1:0]   cpud_addr,
    output logic [XLEN-1:0]   cpud_wdata,
    output logic              cpud_write,
    output logic [XLEN/8-1:0] cpud_byte_enable,
    output logic [1:0]        cpud_size,
    output logic [XLEN-1:0]   p3_alu_out,
    output logic [XLEN-1:0]   p3_jump_addr,
    output logic              p3_jump_taken,
    output logic [XLEN-1:0]   p4_alu_out,
    output logic [XLEN-1:0]   p4_mult,
    output logic              p4_misaligned_addr,
    output logic              exe_busy
);

    localparam int BEW   = XLEN / 8;
    localparam int SHW   = $clog2(XLEN);
    localparam int LANEW = $clog2(BEW);

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_OR   = 6'd4;
    localparam logic [5:0] OP_XOR  = 6'd5;
    localparam logic [5:0] OP_SLL  = 6'd6;
    localparam logic [5:0] OP_SRL  = 6'd7;
    localparam logic [5:0] OP_SRA  = 6'd8;
    localparam logic [5:0] OP_SLT  = 6'd9;
    localparam logic [5:0] OP_BEQ  = 6'd10;
    localparam logic [5:0] OP_BNE  = 6'd11;
    localparam logic [5:0] OP_BLT  = 6'd12;
    localparam logic [5:0] OP_BGE  = 6'd13;
    localparam logic [5:0] OP_JMP  = 6'd14;
    localparam logic [5:0] OP_JMPR = 6'd15;
    localparam logic [5:0] OP_LD   = 6'd16;
    localparam logic [5:0] OP_LDPC = 6'd17;
`ifdef EXEC_MUL_EN
    localparam logic [5:0] OP_MUL  = 6'd18;
`endif

    typedef enum logic {IDLE, REQ} mem_state_t;

    mem_state_t        state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [BEW-1:0]    be_q, be_d;
    logic [1:0]        size_q, size_d;
    logic [XLEN-1:0]   p4_alu_q, p4_alu_d;
    logic              p4_mis_q, p4_mis_d;

    logic [XLEN-1:0]   branch_target;
    logic [XLEN-1:0]   eff_addr;
    logic [SHW-1:0]    shamt;
    logic              a_lt_b;
    logic              jump_cond;
    logic              is_mem;
    logic [1:0]        mem_size;
    logic              mem_misaligned;
    logic [LANEW-1:0]  lane;
    logic [BEW-1:0]    be_base;
    logic              held_busy;
    logic              mem_accept;
    logic              mul_busy;
    logic              unused_opx;

    // opx[0] selects an unsigned comparison for SLT/BLT/BGE; other bits are spare
    assign unused_opx    = ^p3_opx[7:1];
    assign branch_target = p2_pc + (p3_literal << 2);
    assign eff_addr      = p3_data_a + p3_literal;
    assign shamt         = p3_data_b[SHW-1:0];
    assign a_lt_b        = p3_opx[0] ? (p3_data_a < p3_data_b)
                                     : ($signed(p3_data_a) < $signed(p3_data_b));

    // Combinational ALU, shifter, compare and branch/jump resolution
    always_comb begin
        p3_alu_out   = '0;
        p3_jump_addr = '0;
        jump_cond    = 1'b0;
        case (p3_op)
            OP_ADD:  p3_alu_out = p3_data_a + p3_data_b;
            OP_SUB:  p3_alu_out = p3_data_a - p3_data_b;
            OP_AND:  p3_alu_out = p3_data_a & p3_data_b;
            OP_OR:   p3_alu_out = p3_data_a | p3_data_b;
            OP_XOR:  p3_alu_out = p3_data_a ^ p3_data_b;
            OP_SLL:  p3_alu_out = p3_data_a << shamt;
            OP_SRL:  p3_alu_out = p3_data_a >> shamt;
            OP_SRA:  p3_alu_out = $signed(p3_data_a) >>> shamt;
            OP_SLT:  p3_alu_out = {{(XLEN-1){1'b0}}, a_lt_b};
            OP_BEQ:  begin jump_cond = (p3_data_a == p3_data_b); p3_jump_addr = branch_target; end
            OP_BNE:  begin jump_cond = (p3_data_a != p3_data_b); p3_jump_addr = branch_target; end
            OP_BLT:  begin jump_cond = a_lt_b;  p3_jump_addr = branch_target; end
            OP_BGE:  begin jump_cond = ~a_lt_b; p3_jump_addr = branch_target; end
            OP_JMP:  begin jump_cond = 1'b1; p3_jump_addr = branch_target; p3_alu_out = p2_pc; end
            OP_JMPR: begin jump_cond = 1'b1; p3_jump_addr = p3_data_a;     p3_alu_out = p2_pc; end
            OP_LD:   p3_alu_out = p3_literal;
            OP_LDPC: p3_alu_out = branch_target;
            default: ;
        endcase
    end

    assign p3_jump_taken = jump_cond & ~p4_jump_taken;

    // Memory op decode: dword accesses only exist on a 64-bit datapath
    assign mem_size = p3_op[1:0];
    assign is_mem   = (p3_op[5:3] == 3'b100) && ((XLEN == 64) || (mem_size != 2'b11));
    assign lane     = eff_addr[LANEW-1:0];

    // Alignment check and byte-lane mask for the decoded access size
    always_comb begin
        mem_misaligned = 1'b0;
        be_base        = '0;
        case (mem_size)
            2'b00: be_base = BEW'(1);
            2'b01: begin mem_misaligned = eff_addr[0];    be_base = BEW'(3);  end
            2'b10: begin mem_misaligned = |eff_addr[1:0]; be_base = BEW'(15); end
            default: begin mem_misaligned = |eff_addr[2:0]; be_base = '1; end
        endcase
    end

    assign held_busy  = (state_q == REQ) | mul_busy;
    assign mem_accept = is_mem & ~mem_misaligned & ~p4_jump_taken & ~stall & ~held_busy;
    assign exe_busy   = mem_accept | (state_q == REQ) | mul_busy;

    // Bus FSM next state: capture the access on accept, hold it until ack
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        be_d    = be_q;
        size_d  = size_q;
        case (state_q)
            IDLE: begin
                if (mem_accept) begin
                    state_d = REQ;
                    addr_d  = eff_addr;
                    write_d = p3_op[2];
                    size_d  = mem_size;
                    be_d    = be_base << lane;
                    wdata_d = p3_op[2] ? (p3_data_b << {lane, 3'b000}) : '0;
                end
            end
            REQ: begin
                if (cpud_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // p4 result registers advance only when neither downstream nor this stage stalls
    always_comb begin
        p4_alu_d = p4_alu_q;
        p4_mis_d = p4_mis_q;
        if (!stall && !exe_busy) begin
            p4_alu_d = p3_alu_out;
            p4_mis_d = is_mem & mem_misaligned & ~p4_jump_taken;
        end
    end

    // State registers; reset abandons any outstanding bus request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            be_q     <= '0;
            size_q   <= '0;
            p4_alu_q <= '0;
            p4_mis_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            be_q     <= be_d;
            size_q   <= size_d;
            p4_alu_q <= p4_alu_d;
            p4_mis_q <= p4_mis_d;
        end
    end

    assign cpud_request       = (state_q == REQ);
    assign cpud_addr          = addr_q;
    assign cpud_wdata         = wdata_q;
    assign cpud_write         = write_q;
    assign cpud_byte_enable   = be_q;
    assign cpud_size          = size_q;
    assign p4_alu_out         = p4_alu_q;
    assign p4_misaligned_addr = p4_mis_q;

`ifdef EXEC_MUL_EN
    logic                  mul_accept;
    logic [MUL_STAGES-1:0] mul_vld_q, mul_vld_d;
    logic [XLEN-1:0]       mul_prod_q [MUL_STAGES];
    logic [XLEN-1:0]       mul_prod_d [MUL_STAGES];

    assign mul_accept = (p3_op == OP_MUL) & ~p4_jump_taken & ~stall & ~held_busy;

    // Upstream waits while the product is still in any but the final stage
    always_comb begin
        mul_busy = 1'b0;
        for (int i = 0; i < MUL_STAGES - 1; i++) begin
            mul_busy = mul_busy | mul_vld_q[i];
        end
    end

    // Multiplier pipeline: each stage only loads when its predecessor is valid
    always_comb begin
        mul_vld_d     = '0;
        mul_prod_d    = mul_prod_q;
        mul_vld_d[0]  = mul_accept;
        if (mul_accept) begin
            mul_prod_d[0] = p3_data_a * p3_data_b;
        end
        for (int i = 1; i < MUL_STAGES; i++) begin
            mul_vld_d[i] = mul_vld_q[i-1];
            if (mul_vld_q[i-1]) begin
                mul_prod_d[i] = mul_prod_q[i-1];
            end
        end
    end

    // Multiplier stage registers, flushed by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mul_vld_q <= '0;
            for (int i = 0; i < MUL_STAGES; i++) begin
                mul_prod_q[i] <= '0;
            end
        end else begin
            mul_vld_q  <= mul_vld_d;
            mul_prod_q <= mul_prod_d;
        end
    end

    assign p4_mult = mul_prod_q[MUL_STAGES-1];
`else
    logic unused_mul_cfg;

    assign unused_mul_cfg = (MUL_STAGES != 0);
    assign mul_busy       = 1'b0;
    assign p4_mult        = '0;
`endif

endmodule

// File: tb/tb_cpu_execute_pipe.sv
// Directed testbench for cpu_execute_pipe: one XLEN=32/MUL_STAGES=3 instance
// and one XLEN=64 instance, checked against hand-computed values.
module tb_cpu_execute_pipe;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_SLL  = 6'd6;
    localparam logic [5:0] OP_SRA  = 6'd8;
    localparam logic [5:0] OP_SLT  = 6'd9;
    localparam logic [5:0] OP_BEQ  = 6'd10;
    localparam logic [5:0] OP_BNE  = 6'd11;
    localparam logic [5:0] OP_JMPR = 6'd15;
    localparam logic [5:0] OP_LDPC = 6'd17;
    localparam logic [5:0] OP_MUL  = 6'd18;
    localparam logic [5:0] OP_LDH  = 6'd33;
    localparam logic [5:0] OP_LDW  = 6'd34;
    localparam logic [5:0] OP_LDD  = 6'd35;
    localparam logic [5:0] OP_STB  = 6'd36;
    localparam logic [5:0] OP_STW  = 6'd38;
    localparam logic [5:0] OP_STD  = 6'd39;

    logic        clock;
    int          error_count;
    int          check_count;

    logic        reset_32, stall_32, jt_in_32, ack_32;
    logic [5:0]  op_32;
    logic [7:0]  opx_32;
    logic [31:0] a_32, b_32, lit_32, pc_32;
    logic        req_32, write_32, jt_out_32, mis_32, busy_32;
    logic [31:0] addr_32, wdata_32, alu_32, jaddr_32, p4_alu_32, mult_32;
    logic [3:0]  be_32;
    logic [1:0]  size_32;

    logic        reset_64, stall_64, jt_in_64, ack_64;
    logic [5:0]  op_64;
    logic [7:0]  opx_64;
    logic [63:0] a_64, b_64, lit_64, pc_64;
    logic        req_64, write_64, jt_out_64, mis_64, busy_64;
    logic [63:0] addr_64, wdata_64, alu_64, jaddr_64, p4_alu_64, mult_64;
    logic [7:0]  be_64;
    logic [1:0]  size_64;

    cpu_execute_pipe #(.XLEN(32), .MUL_STAGES(3)) dut_32 (
        .clock(clock), .reset(reset_32), .stall(stall_32),
        .p3_op(op_32), .p3_opx(opx_32), .p3_data_a(a_32), .p3_data_b(b_32),
        .p3_literal(lit_32), .p2_pc(pc_32), .p4_jump_taken(jt_in_32),
        .cpud_request(req_32), .cpud_ack(ack_32), .cpud_addr(addr_32),
        .cpud_wdata(wdata_32), .cpud_write(write_32), .cpud_byte_enable(be_32),
        .cpud_size(size_32), .p3_alu_out(alu_32), .p3_jump_addr(jaddr_32),
        .p3_jump_taken(jt_out_32), .p4_alu_out(p4_alu_32), .p4_mult(mult_32),
        .p4_misaligned_addr(mis_32), .exe_busy(busy_32)
    );

    cpu_execute_pipe #(.XLEN(64), .MUL_STAGES(2)) dut_64 (
        .clock(clock), .reset(reset_64), .stall(stall_64),
        .p3_op(op_64), .p3_opx(opx_64), .p3_data_a(a_64), .p3_data_b(b_64),
        .p3_literal(lit_64), .p2_pc(pc_64), .p4_jump_taken(jt_in_64),
        .cpud_request(req_64), .cpud_ack(ack_64), .cpud_addr(addr_64),
        .cpud_wdata(wdata_64), .cpud_write(write_64), .cpud_byte_enable(be_64),
        .cpud_size(size_64), .p3_alu_out(alu_64), .p3_jump_addr(jaddr_64),
        .p3_jump_taken(jt_out_64), .p4_alu_out(p4_alu_64), .p4_mult(mult_64),
        .p4_misaligned_addr(mis_64), .exe_busy(busy_64)
    );

    // Free-running 10-unit clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic sel_64, input logic [5:0] op,
                                 input logic [7:0] opx, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] lit);
        if (sel_64) begin
            op_64 = op; opx_64 = opx; a_64 = a; b_64 = b; lit_64 = lit;
        end else begin
            op_32 = op; opx_32 = opx; a_32 = a[31:0]; b_32 = b[31:0]; lit_32 = lit[31:0];
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    // Directed stimulus sequence
    initial begin
        error_count = 0;
        check_count = 0;
        reset_32 = 1'b0; stall_32 = 1'b0; jt_in_32 = 1'b0; ack_32 = 1'b0; pc_32 = '0;
        reset_64 = 1'b0; stall_64 = 1'b0; jt_in_64 = 1'b0; ack_64 = 1'b0; pc_64 = '0;
        applyStimulus(1'b0, OP_NOP, 8'h0, 0, 0, 0);
        applyStimulus(1'b1, OP_NOP, 8'h0, 0, 0, 0);

        sample();
        checkOutput("rst_request",  req_32,    0);
        checkOutput("rst_write",    write_32,  0);
        checkOutput("rst_be",       be_32,     0);
        checkOutput("rst_addr",     addr_32,   0);
        checkOutput("rst_wdata",    wdata_32,  0);
        checkOutput("rst_size",     size_32,   0);
        checkOutput("rst_p4_alu",   p4_alu_32, 0);
        checkOutput("rst_p4_mult",  mult_32,   0);
        checkOutput("rst_misalign", mis_32,    0);
        checkOutput("rst_busy",     busy_32,   0);
        checkOutput("rst64_request", req_64,   0);
        checkOutput("rst64_p4_alu", p4_alu_64, 0);

        next_cycle();
        reset_32 = 1'b1;
        reset_64 = 1'b1;

        applyStimulus(1'b0, OP_ADD, 8'h0, 5, 7, 0);
        sample();
        checkOutput("add_alu", alu_32, 12);
        checkOutput("add_busy", busy_32, 0);
        next_cycle();
        applyStimulus(1'b0, OP_SUB, 8'h0, 3, 5, 0);
        sample();
        checkOutput("add_p4_alu", p4_alu_32, 12);
        checkOutput("sub_alu", alu_32, 64'hFFFF_FFFE);
        next_cycle();
        applyStimulus(1'b0, OP_SRA, 8'h0, 64'h8000_0000, 36, 0);
        sample();
        checkOutput("sra_masked_shamt", alu_32, 64'hF800_0000);
        next_cycle();
        applyStimulus(1'b0, OP_SLT, 8'h0, 64'hFFFF_FFFF, 1, 0);
        sample();
        checkOutput("slt_signed", alu_32, 1);
        next_cycle();
        applyStimulus(1'b0, OP_SLT, 8'h1, 64'hFFFF_FFFF, 1, 0);
        sample();
        checkOutput("slt_unsigned", alu_32, 0);
        next_cycle();
        pc_32 = 32'h1000;
        applyStimulus(1'b0, OP_BEQ, 8'h0, 9, 9, 3);
        sample();
        checkOutput("beq_taken", jt_out_32, 1);
        checkOutput("beq_target", jaddr_32, 64'h100C);
        next_cycle();
        applyStimulus(1'b0, OP_BNE, 8'h0, 9, 9, 3);
        sample();
        checkOutput("bne_not_taken", jt_out_32, 0);
        next_cycle();
        applyStimulus(1'b0, OP_JMPR, 8'h0, 64'h2000, 0, 0);
        sample();
        checkOutput("jmpr_taken", jt_out_32, 1);
        checkOutput("jmpr_target", jaddr_32, 64'h2000);
        checkOutput("jmpr_link", alu_32, 64'h1000);
        next_cycle();
        applyStimulus(1'b0, OP_LDPC, 8'h0, 0, 0, 5);
        sample();
        checkOutput("ldpc_alu", alu_32, 64'h1014);

        next_cycle();
        applyStimulus(1'b0, OP_ADD, 8'h0, 20, 22, 0);
        next_cycle();
        stall_32 = 1'b1;
        applyStimulus(1'b0, OP_ADD, 8'h0, 1, 1, 0);
        sample();
        checkOutput("p4_alu_before_stall", p4_alu_32, 42);
        next_cycle();
        stall_32 = 1'b0;
        sample();
        checkOutput("p4_alu_frozen", p4_alu_32, 42);
        next_cycle();
        applyStimulus(1'b0, OP_NOP, 8'h0, 0, 0, 0);
        sample();
        checkOutput("p4_alu_after_stall", p4_alu_32, 2);

        next_cycle();
        applyStimulus(1'b0, OP_STW, 8'h0, 64'h100, 64'hDEAD_BEEF, 4);
        sample();
        checkOutput("stw_accept_busy", busy_32, 1);
        checkOutput("stw_accept_noreq", req_32, 0);
        next_cycle();
        applyStimulus(1'b0, OP_NOP, 8'h0, 0, 0, 0);
        sample();
        checkOutput("stw_r1_request", req_32, 1);
        checkOutput("stw_r1_addr", addr_32, 64'h104);
        checkOutput("stw_r1_be", be_32, 4'b1111);
        checkOutput("stw_r1_wdata", wdata_32, 64'hDEAD_BEEF);
        checkOutput("stw_r1_write", write_32, 1);
        checkOutput("stw_r1_size", size_32, 2);
        checkOutput("stw_r1_busy", busy_32, 1);
        next_cycle();
        sample();
        checkOutput("stw_r2_request", req_32, 1);
        checkOutput("stw_r2_wdata", wdata_32, 64'hDEAD_BEEF);
        checkOutput("stw_r2_addr", addr_32, 64'h104);
        next_cycle();
        ack_32 = 1'b1;
        applyStimulus(1'b0, OP_LDW, 8'h0, 64'h200, 0, 0);
        sample();
        checkOutput("stw_r3_request", req_32, 1);
        checkOutput("stw_r3_busy", busy_32, 1);
        next_cycle();
        ack_32 = 1'b0;
        sample();
        checkOutput("b2b_not_early", req_32, 0);
        checkOutput("b2b_accept_busy", busy_32, 1);
        next_cycle();
        applyStimulus(1'b0, OP_NOP, 8'h0, 0, 0, 0);
        ack_32 = 1'b1;
        sample();
        checkOutput("ldw_request", req_32, 1);
        checkOutput("ldw_addr", addr_32, 64'h200);
        checkOutput("ldw_write", write_32, 0);
        next_cycle();
        ack_32 = 1'b0;
        sample();
        checkOutput("ldw_done_request", req_32, 0);
        checkOutput("ldw_done_busy", busy_32, 0);

        next_cycle();
        applyStimulus(1'b0, OP_STB, 8'h0, 64'h100, 64'h5A, 3);
        next_cycle();
        applyStimulus(1'b0, OP_NOP, 8'h0, 0, 0, 0);
        ack_32 = 1'b1;
        sample();
        checkOutput("stb_request", req_32, 1);
        checkOutput("stb_be", be_32, 4'b1000);
        checkOutput("stb_wdata", wdata_32, 64'h5A00_0000);
        checkOutput("stb_size", size_32, 0);
        next_cycle();
        ack_32 = 1'b0;
        sample();
        checkOutput("stb_done", req_32, 0);

        applyStimulus(1'b0, OP_LDH, 8'h0, 64'h100, 0, 1);
        sample();
        checkOutput("ldh_mis_busy", busy_32, 0);
        next_cycle();
        applyStimulus(1'b0, OP_NOP, 8'h0, 0, 0, 0);
        sample();
        checkOutput("ldh_mis_noreq", req_32, 0);
        checkOutput("ldh_mis_flag", mis_32, 1);
        next_cycle();
        sample();
        checkOutput("mis_flag_clears", mis_32, 0);

        applyStimulus(1'b0, OP_MUL, 8'h0, 7, 64'hFFFF_FFFD, 0);
        sample();
        checkOutput("mul_accept_busy", busy_32, 0);
        next_cycle();
        applyStimulus(1'b0, OP_NOP, 8'h0, 0, 0, 0);
        sample();
`ifdef EXEC_MUL_EN
        checkOutput("mul_c1_busy", busy_32, 1);
`else
        checkOutput("mul_c1_busy", busy_32, 0);
`endif
        next_cycle();
        sample();
`ifdef EXEC_MUL_EN
        checkOutput("mul_c2_busy", busy_32, 1);
`else
        checkOutput("mul_c2_busy", busy_32, 0);
`endif
        checkOutput("mul_not_early", mult_32, 0);
        next_cycle();
        sample();
        checkOutput("mul_c3_busy", busy_32, 0);
`ifdef EXEC_MUL_EN
        checkOutput("mul_result", mult_32, 64'hFFFF_FFEB);
`else
        checkOutput("mul_result", mult_32, 0);
`endif

        next_cycle();
        jt_in_32 = 1'b1;
        applyStimulus(1'b0, OP_BEQ, 8'h0, 4, 4, 1);
        sample();
        checkOutput("beq_nullified", jt_out_32, 0);
        next_cycle();
        applyStimulus(1'b0, OP_LDW, 8'h0, 64'h300, 0, 0);
        sample();
        checkOutput("ldw_nullified_busy", busy_32, 0);
        next_cycle();
        jt_in_32 = 1'b0;
        applyStimulus(1'b0, OP_NOP, 8'h0, 0, 0, 0);
        sample();
        checkOutput("ldw_nullified_noreq", req_32, 0);
        next_cycle();
        sample();
        checkOutput("ldw_nullified_idle", req_32, 0);

        applyStimulus(1'b0, 6'h3F, 8'h0, 1, 2, 3);
        sample();
        checkOutput("unknown_jump", jt_out_32, 0);
        checkOutput("unknown_busy", busy_32, 0);
        checkOutput("unknown_alu", alu_32, 0);
        next_cycle();
        applyStimulus(1'b0, OP_LDD, 8'h0, 64'h100, 0, 1);
        sample();
        checkOutput("unknown_noreq", req_32, 0);
        checkOutput("ldd32_busy", busy_32, 0);
        next_cycle();
        applyStimulus(1'b0, OP_NOP, 8'h0, 0, 0, 0);
        sample();
        checkOutput("ldd32_noreq", req_32, 0);
        checkOutput("ldd32_no_misalign", mis_32, 0);

        next_cycle();
        applyStimulus(1'b1, OP_SLL, 8'h0, 1, 63, 0);
        sample();
        checkOutput("sll64_msb", alu_64, 64'h8000_0000_0000_0000);
        next_cycle();
        applyStimulus(1'b1, OP_SLL, 8'h0, 1, 65, 0);
        sample();
        checkOutput("sll64_masked_shamt", alu_64, 2);
        next_cycle();
        applyStimulus(1'b1, OP_STD, 8'h0, 64'h1000, 64'h1122_3344_5566_7788, 8);
        sample();
        checkOutput("std64_accept_busy", busy_64, 1);
        next_cycle();
        applyStimulus(1'b1, OP_NOP, 8'h0, 0, 0, 0);
        sample();
        checkOutput("std64_request", req_64, 1);
        checkOutput("std64_addr", addr_64, 64'h1008);
        checkOutput("std64_be", be_64, 8'hFF);
        checkOutput("std64_size", size_64, 3);
        #2;
        reset_64 = 1'b0;
        #1;
        checkOutput("rst_mid_req_async", req_64, 0);
        checkOutput("rst_mid_req_busy", busy_64, 0);
        next_cycle();
        reset_64 = 1'b1;
        sample();
        checkOutput("rst_no_retry_1", req_64, 0);
        next_cycle();
        sample();
        checkOutput("rst_no_retry_2", req_64, 0);

        applyStimulus(1'b1, OP_STW, 8'h0, 64'h1000, 64'hCAFE_BABE, 4);
        next_cycle();
        applyStimulus(1'b1, OP_NOP, 8'h0, 0, 0, 0);
        ack_64 = 1'b1;
        sample();
        checkOutput("stw64_be", be_64, 8'hF0);
        checkOutput("stw64_wdata", wdata_64, 64'hCAFE_BABE_0000_0000);
        next_cycle();
        ack_64 = 1'b0;
        sample();
        checkOutput("stw64_done", req_64, 0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule

// File: doc/cpu_execute_pipe.md
CPU_EXECUTE_PIPE -- requirements
Module: cpu_execute_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter MUL_STAGES, default 2, multiplier pipeline depth; legal range 1..4.
REQ-003 SHALL have clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have stall  input  1  downstream stall; freezes the p4 registers.
REQ-006 SHALL have p3_op / p3_opx  input  6 / 8  operation and op-specific parameters, with opcodes from cpu.vh.
REQ-007 SHALL have p3_data_a, p3_data_b, p3_literal, p2_pc  input  XLEN  operands, literal and decode-stage PC.
REQ-008 SHALL have p4_jump_taken  input  1  nullifies the current p3 instruction.
REQ-009 SHALL have cpud_request  output  1  registered bus request, held until acknowledged.
REQ-010 SHALL have cpud_ack  input  1  bus accepts the request in the cycle it is high with cpud_request.
REQ-011 SHALL have cpud_addr, cpud_wdata  output  XLEN  registered address and write data.
REQ-012 SHALL have cpud_write  output  1, cpud_byte_enable  output  XLEN/8, and cpud_size  output  2 (00 byte, 01 half, 10 word, 11 dword).
REQ-013 SHALL have p3_alu_out, p3_jump_addr  output  XLEN, and p3_jump_taken  output  1  (all combinational).
REQ-014 SHALL have p4_alu_out, p4_mult  output  XLEN, and p4_misaligned_addr  output  1  (all registered).
REQ-015 SHALL have exe_busy  output  1  requests an upstream stall while a memory or multiply operation is outstanding.

Function
REQ-016 ALU, shift, compare, branch, JMP/JMPR, LD and LDPC ops SHALL be computed combinationally at XLEN width.
- Shift amount: low log2(XLEN) bits of p3_data_b.
- branch_target = p2_pc + (p3_literal << 2).
REQ-017 Effective address SHALL be p3_data_a + p3_literal; an access is misaligned when any address bit below log2(access bytes) is set.
REQ-018 Memory FSM SHALL have states IDLE and REQ.
- IDLE -> REQ on an accepted memory op: load/store op, not misaligned, not nullified, stall=0.
- On that edge: capture addr, size, write, byte_enable and lane-shifted wdata.
REQ-019 In REQ, cpud_request=1 and the captured fields SHALL be held stable; REQ -> IDLE on the edge where cpud_ack=1.
REQ-020 exe_busy SHALL be 1 from the accept cycle through the ack cycle inclusive; a back-to-back memory op is accepted no earlier than the cycle after ack.
REQ-021 A misaligned memory op SHALL NOT enter REQ and SHALL set p4_misaligned_addr=1 at the next p4 update.
REQ-022 OP_MUL SHALL produce the low XLEN bits of a*b.
- Result appears on p4_mult exactly MUL_STAGES cycles after accept.
- exe_busy is held for MUL_STAGES-1 cycles after accept.
REQ-023 p4_alu_out and p4_misaligned_addr SHALL load only when stall=0 and exe_busy=0.
REQ-024 p4_jump_taken=1 SHALL force p3_jump_taken=0 and suppress memory and multiply accept; an already-launched REQ SHALL complete.
REQ-025 Unknown opcodes SHALL have no side effects: no request, no jump, exe_busy=0.

Reset
REQ-026 While reset=0, the block SHALL be in the following state:
- FSM in IDLE, multiplier pipeline flushed;
- cpud_request=0, cpud_write=0, cpud_byte_enable=0, cpud_addr=0, cpud_wdata=0, cpud_size=0;
- p4_alu_out=0, p4_mult=0, p4_misaligned_addr=0, exe_busy=0.
REQ-027 Reset asserted mid-REQ SHALL drop cpud_request immediately, and the abandoned transaction SHALL NOT be retried.

Configuration
REQ-028 Macro EXEC_MUL_EN, when defined, SHALL build the MUL_STAGES multiplier.
- When undefined, OP_MUL takes the no-side-effect path and p4_mult is constant 0.
- All other behaviour is identical in both builds.

Verification
REQ-029 XLEN=32, STW a=0x100, lit=4, b=0xDEADBEEF, ack delayed 3 cycles -> request held 3 cycles at addr 0x104, be=1111, wdata stable, exe_busy high through the ack cycle.
REQ-030 STB addr 0x103, b=0x5A -> be=1000, wdata[31:24]=0x5A; LDH addr 0x101 -> no request, p4_misaligned_addr=1.
REQ-031 EXEC_MUL_EN, MUL_STAGES=3, a=7, b=-3 -> p4_mult=0xFFFFFFEB 3 cycles after accept, exe_busy high 2 cycles.
REQ-032 BEQ with a=b and p4_jump_taken=1 -> p3_jump_taken=0; then LDW with p4_jump_taken=1 -> no request, FSM stays in IDLE.
REQ-033 XLEN=64, SLL a=1, b=63 -> p3_alu_out=0x8000000000000000; reset pulsed mid-REQ -> cpud_request=0 asynchronously.
